// File: rtl/stoch_signed_pool_decoder_pkg.sv
// Shared types and width helper for the dual-rail bitstream decoder.
package stoch_decode_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} dec_state_t;

  // Signed count width able to hold +/-window without overflow.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1) + 1;
  endfunction

endpackage

// File: rtl/stoch_signed_pool_decoder_counter.sv
// Per-lane signed up/down counter: +1 on p-only, -1 on m-only, hold otherwise.
module stoch_signed_counter #(
  parameter int CNT_W = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    p,
  input  logic                    m,
  output logic signed [CNT_W-1:0] acc
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en) begin
      if (p && !m)
        acc <= acc + CNT_W'(1);
      else if (m && !p)
        acc <= acc - CNT_W'(1);
    end
  end

endmodule

// File: rtl/stoch_signed_pool_decoder.sv
// Decodes dual-rail stochastic bitstreams into signed counts over a WINDOW-cycle window,
// launched by start and presented under a valid/ready handshake.
module stoch_signed_pool_decoder
  import stoch_decode_pkg::*;
#(
  parameter  int NUM_LANES = 27,
  parameter  int WINDOW    = 256,
  localparam int CNT_W     = cnt_width(WINDOW)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_LANES-1:0]            x_p,
  input  logic [NUM_LANES-1:0]            x_m,
  input  logic                            start,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES-1:0][CNT_W-1:0] y
);

  localparam int WC_W = $clog2(WINDOW);

  dec_state_t                       state;
  logic [WC_W-1:0]                  cnt;
  logic                             hs, launch, en, last;
  logic [NUM_LANES-1:0][CNT_W-1:0]  acc, fin;

  assign hs     = out_valid & out_ready;
  // Accumulators clear on both launch paths, including the zero-bubble restart from DONE.
  assign launch = ((state == IDLE) && start) || ((state == DONE) && hs && start);
  assign en     = (state == ACCUM);
  assign last   = en && (cnt == WC_W'(WINDOW - 1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    stoch_signed_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .clr (launch),
      .en  (en),
      .p   (x_p[g]),
      .m   (x_m[g]),
      .acc (acc[g])
    );
    // Final value must include the sample taken on the closing edge.
    assign fin[g] = acc[g] + ((x_p[g] & ~x_m[g]) ? CNT_W'(1) :
                              (x_m[g] & ~x_p[g]) ? {CNT_W{1'b1}} : '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        ACCUM: begin
          cnt <= cnt + WC_W'(1);
          if (last) begin
            y         <= fin;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: if (hs) begin
          out_valid <= 1'b0;
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_signed_pool_decoder.sv
// Directed table vectors and corner sequences on a WINDOW=8 instance, random windows on WINDOW=256.
module tb_stoch_signed_pool_decoder;
  import stoch_decode_pkg::*;

  localparam int NL    = 27;
  localparam int CW8   = cnt_width(8);
  localparam int CW256 = cnt_width(256);

  logic clk = 1'b0;
  logic rst;
  logic [NL-1:0] xp8, xm8, xp2, xm2;
  logic start8, ready8, busy8, valid8;
  logic start2, ready2, busy2, valid2;
  logic [NL-1:0][CW8-1:0]   y8;
  logic [NL-1:0][CW256-1:0] y2;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  stoch_signed_pool_decoder #(.NUM_LANES(NL), .WINDOW(8)) dut8 (
    .CLK(clk), .RST(rst), .x_p(xp8), .x_m(xm8), .start(start8), .busy(busy8),
    .out_valid(valid8), .out_ready(ready8), .y(y8)
  );

  stoch_signed_pool_decoder #(.NUM_LANES(NL), .WINDOW(256)) dut256 (
    .CLK(clk), .RST(rst), .x_p(xp2), .x_m(xm2), .start(start2), .busy(busy2),
    .out_valid(valid2), .out_ready(ready2), .y(y2)
  );

  typedef struct {
    logic [NL-1:0] p;
    logic [NL-1:0] m;
    int e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int yl8(input int i);
    return int'($signed(y8[i]));
  endfunction

  function automatic int yl2(input int i);
    return int'($signed(y2[i]));
  endfunction

  // Launch a window with constant inputs and check the exact completion edge.
  task automatic run8(input logic [NL-1:0] p, input logic [NL-1:0] m);
    xp8 = p; xm8 = m; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("busy_after_start", int'(busy8), 1);
    repeat (7) step();
    chk("valid_before_last", int'(valid8), 0);
    step();
    chk("valid_at_last", int'(valid8), 1);
    chk("busy_at_last", int'(busy8), 0);
  endtask

  task automatic ack8();
    ready8 = 1'b1;
    step();
    ready8 = 1'b0;
    chk("valid_after_ack", int'(valid8), 0);
    chk("busy_after_ack", int'(busy8), 0);
  endtask

  initial begin
    int nz, bad, stall;
    int sum[NL];
    bit pend;

    vecs[0] = '{p: 27'h1, m: 27'h2, e0:  8, e1: -8, e2:  0, e3:  0};
    vecs[1] = '{p: 27'h5, m: 27'h1, e0:  0, e1:  0, e2:  8, e3:  0};
    vecs[2] = '{p: 27'h0, m: 27'hF, e0: -8, e1: -8, e2: -8, e3: -8};
    vecs[3] = '{p: 27'hA, m: 27'h3, e0: -8, e1:  0, e2:  0, e3:  8};

    rst = 1'b1;
    xp8 = '0; xm8 = '0; start8 = 1'b0; ready8 = 1'b0;
    xp2 = '0; xm2 = '0; start2 = 1'b0; ready2 = 1'b0;
    step(); step();
    chk("rst_busy", int'(busy8), 0);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_y", int'(y8 != '0), 0);
    rst = 1'b0;
    step();

    // Table of constant-input windows
    for (int v = 0; v < 4; v++) begin
      run8(vecs[v].p, vecs[v].m);
      chk($sformatf("vec%0d_y0", v), yl8(0), vecs[v].e0);
      chk($sformatf("vec%0d_y1", v), yl8(1), vecs[v].e1);
      chk($sformatf("vec%0d_y2", v), yl8(2), vecs[v].e2);
      chk($sformatf("vec%0d_y3", v), yl8(3), vecs[v].e3);
      nz = 0;
      for (int i = 4; i < NL; i++) if (y8[i] != '0) nz++;
      chk($sformatf("vec%0d_rest", v), nz, 0);
      ack8();
    end

    // Lane0 p=m cancels; lane2 minus rail for only three samples
    xp8 = 27'h1; xm8 = 27'h5; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    xm8 = 27'h1;
    repeat (4) step();
    chk("partial_valid_early", int'(valid8), 0);
    step();
    chk("partial_valid", int'(valid8), 1);
    chk("partial_y0", yl8(0), 0);
    chk("partial_y2", yl8(2), -3);

    // Stall in DONE with a start pulse that must be ignored
    for (int c = 0; c < 5; c++) begin
      start8 = (c == 2);
      xp8 = 27'h7FFFFFF; xm8 = '0;
      step();
      chk("stall_valid", int'(valid8), 1);
      chk("stall_busy", int'(busy8), 0);
      chk("stall_y2", yl8(2), -3);
      chk("stall_y0", yl8(0), 0);
    end
    start8 = 1'b0;
    ack8();
    repeat (3) step();
    chk("idle_after_stall", int'(busy8), 0);

    // Reset in the middle of an accumulation
    xp8 = 27'h1; xm8 = '0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(valid8), 0);
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_y", int'(y8 != '0), 0);
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    chk("postrst_no_window", int'(busy8) + int'(valid8), 0);
    run8(27'h1, '0);
    chk("postrst_y0", yl8(0), 8);
    ack8();

    // Back-to-back: restart from DONE in the handshake cycle
    run8('0, 27'h2);
    chk("b2b_w1_y0", yl8(0), 0);
    chk("b2b_w1_y1", yl8(1), -8);
    xp8 = 27'h1; xm8 = '0; ready8 = 1'b1; start8 = 1'b1;
    step();
    ready8 = 1'b0; start8 = 1'b0;
    chk("b2b_busy", int'(busy8), 1);
    chk("b2b_valid_drop", int'(valid8), 0);
    repeat (7) step();
    chk("b2b_valid_early", int'(valid8), 0);
    step();
    chk("b2b_valid", int'(valid8), 1);
    chk("b2b_w2_y0", yl8(0), 8);
    chk("b2b_w2_y1", yl8(1), 0);
    ack8();

    // Random windows on the full-size instance with stalls and back-to-back restarts
    pend = 1'b0;
    for (int w = 0; w < 100; w++) begin
      xp2 = NL'($urandom); xm2 = NL'($urandom);
      start2 = 1'b1; ready2 = pend;
      step();
      start2 = 1'b0; ready2 = 1'b0;
      chk("rand_busy", int'(busy2), 1);
      for (int i = 0; i < NL; i++) sum[i] = 0;
      for (int c = 0; c < 256; c++) begin
        xp2 = NL'($urandom); xm2 = NL'($urandom);
        for (int i = 0; i < NL; i++) sum[i] += int'(xp2[i]) - int'(xm2[i]);
        step();
      end
      chk("rand_valid", int'(valid2), 1);
      stall = $urandom_range(0, 3);
      repeat (stall) step();
      bad = 0;
      for (int i = 0; i < NL; i++) begin
        if (yl2(i) != sum[i]) begin
          bad++;
          if (bad == 1)
            $display("FAIL rand_lane w%0d l%0d: got %0d expected %0d", w, i, yl2(i), sum[i]);
        end
      end
      chk("rand_window", bad, 0);
      pend = bit'($urandom_range(0, 1));
      if (!pend) begin
        ready2 = 1'b1;
        step();
        ready2 = 1'b0;
        chk("rand_ack", int'(valid2), 0);
      end
    end
    if (pend) begin
      ready2 = 1'b1;
      step();
      ready2 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
